fifo_gray_level: RTL and testbench

//  Consumer end of a FIFO Gray-pointer crossing. Takes a remote Gray-coded (W+1)-bit pointer that is

---
 rtl/fifo_gray_level.sv | 120 ++++++++++++
 tb/tb_fifo_gray_level.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fifo_gray_level.sv
// fifo_gray_level: consumer end of a Gray-pointer FIFO crossing; decodes the remote pointer and derives level/flags.
// Optional macro FIFO_GRAY_LEVEL_CHECK_EN adds sticky pointer-consistency checking with level clamping.
module fifo_gray_level #(
    parameter int C_ADDRESS_WIDTH      = 4,
    parameter bit C_LOCAL_IS_WRITER    = 1'b0,
    parameter int C_ALMOST_EMPTY_LEVEL = 2,
    parameter int C_ALMOST_FULL_LEVEL  = 14
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [C_ADDRESS_WIDTH:0]   remote_gray,
    input  logic [C_ADDRESS_WIDTH:0]   local_addr,
    output logic [C_ADDRESS_WIDTH:0]   remote_addr,
    output logic [C_ADDRESS_WIDTH:0]   level,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic                       ptr_error
);
    localparam int         W      = C_ADDRESS_WIDTH;
    localparam logic [W:0] DEPTH  = {1'b1, {W{1'b0}}};
    localparam logic [W:0] AE_LVL = (W+1)'(C_ALMOST_EMPTY_LEVEL);
    localparam logic [W:0] AF_LVL = (W+1)'(C_ALMOST_FULL_LEVEL);

    if (!((C_ALMOST_EMPTY_LEVEL < C_ALMOST_FULL_LEVEL) &&
          (C_ALMOST_FULL_LEVEL <= (1 << C_ADDRESS_WIDTH)) &&
          (C_ADDRESS_WIDTH >= 2))) begin : g_param_check
        $error("fifo_gray_level: illegal parameter combination");
    end

    logic [W:0] remote_bin_d, remote_bin_q;
    logic [W:0] local_d, local_q;
    logic [W:0] diff;
    logic [W:0] level_d, level_q;
    logic       empty_d, empty_q;
    logic       full_d, full_q;
    logic       almost_empty_d, almost_empty_q;
    logic       almost_full_d, almost_full_q;
`ifdef FIFO_GRAY_LEVEL_CHECK_EN
    logic       overflow;
    logic       err_d, err_q;
`endif

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        remote_bin_d    = '0;
        remote_bin_d[W] = remote_gray[W];
        for (int i = W - 1; i >= 0; i--) begin
            remote_bin_d[i] = remote_bin_d[i+1] ^ remote_gray[i];
        end
        local_d = local_addr;
    end

    always_comb begin
        diff = '0;
        if (C_LOCAL_IS_WRITER) begin
            diff = local_q - remote_bin_q;
        end else begin
            diff = remote_bin_q - local_q;
        end
    end

    always_comb begin
        level_d = diff;
`ifdef FIFO_GRAY_LEVEL_CHECK_EN
        overflow = (diff > DEPTH);
        err_d    = err_q | overflow;
        if (overflow) begin
            level_d = DEPTH;
        end
`endif
        empty_d        = (level_d == '0);
        full_d         = (level_d == DEPTH);
        almost_empty_d = (level_d <= AE_LVL);
        almost_full_d  = (level_d >= AF_LVL);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            remote_bin_q   <= '0;
            local_q        <= '0;
            level_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
        end else begin
            remote_bin_q   <= remote_bin_d;
            local_q        <= local_d;
            level_q        <= level_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_empty_q <= almost_empty_d;
            almost_full_q  <= almost_full_d;
        end
    end

`ifdef FIFO_GRAY_LEVEL_CHECK_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ptr_error = err_q;
`else
    assign ptr_error = 1'b0;
`endif

    assign remote_addr  = remote_bin_q;
    assign level        = level_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = almost_empty_q;
    assign almost_full  = almost_full_q;

endmodule

// File: tb/tb_fifo_gray_level.sv
// Scoreboard bench for fifo_gray_level: reader-side and writer-side instances, W=4, default thresholds.
module tb_fifo_gray_level;
    logic       clk = 1'b0;
    int         cyc = 0;
    logic       areset_a, areset_w;
    logic [4:0] gray_a, local_a, gray_w, local_w;
    logic [4:0] ra_a, lvl_a, ra_w, lvl_w;
    logic       e_a, f_a, ae_a, af_a, err_a;
    logic       e_w, f_w, ae_w, af_w, err_w;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         due;
        bit         wr;
        string      name;
        logic [4:0] lvl;
        logic [4:0] flg;   // {empty, full, almost_empty, almost_full, ptr_error}
        bit         chk_ra;
        logic [4:0] ra;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_gray_level dut_a (
        .aclk(clk), .areset(areset_a), .remote_gray(gray_a), .local_addr(local_a),
        .remote_addr(ra_a), .level(lvl_a), .empty(e_a), .full(f_a),
        .almost_empty(ae_a), .almost_full(af_a), .ptr_error(err_a)
    );

    fifo_gray_level #(.C_LOCAL_IS_WRITER(1'b1)) dut_w (
        .aclk(clk), .areset(areset_w), .remote_gray(gray_w), .local_addr(local_w),
        .remote_addr(ra_w), .level(lvl_w), .empty(e_w), .full(f_w),
        .almost_empty(ae_w), .almost_full(af_w), .ptr_error(err_w)
    );

    always @(negedge clk) begin
        exp_t       x;
        logic [4:0] a_lvl, a_flg, a_ra;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            x = sb.pop_front();
            if (x.wr) begin
                a_lvl = lvl_w; a_ra = ra_w; a_flg = {e_w, f_w, ae_w, af_w, err_w};
            end else begin
                a_lvl = lvl_a; a_ra = ra_a; a_flg = {e_a, f_a, ae_a, af_a, err_a};
            end
            n_vec++;
            if (x.due != cyc || a_lvl !== x.lvl || a_flg !== x.flg ||
                (x.chk_ra && a_ra !== x.ra)) begin
                n_err++;
                $display("FAIL %s: got level=%0d flags(e,f,ae,af,err)=%b remote_addr=%0d, expected level=%0d flags=%b remote_addr=%0d (cycle %0d, due %0d)",
                         x.name, a_lvl, a_flg, a_ra, x.lvl, x.flg, x.ra, cyc, x.due);
            end
        end
    end

    task automatic chk(input int lat, input bit wr, input string nm, input int lvl,
                       input logic [4:0] flg, input bit cra, input int ra);
        exp_t x;
        x.due = cyc + lat; x.wr = wr; x.name = nm; x.lvl = 5'(lvl);
        x.flg = flg; x.chk_ra = cra; x.ra = 5'(ra);
        sb.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [4:0] g_tab[5];

    initial begin
        g_tab = '{5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111};
        areset_a = 1'b1; areset_w = 1'b1;
        gray_a = 5'b10110; local_a = 5'b01101;
        gray_w = 5'b01011; local_w = 5'b11100;
        tick(1);

        // reset with arbitrary inputs
        chk(1, 0, "reset_c1", 0, 5'b10100, 1, 0);
        chk(2, 0, "reset_c2", 0, 5'b10100, 1, 0);
        chk(3, 0, "reset_c3", 0, 5'b10100, 1, 0);
        chk(3, 1, "reset_wr", 0, 5'b10100, 1, 0);
        tick(3);
        areset_a = 1'b0; areset_w = 1'b0;
        gray_a = 5'd0; local_a = 5'd0; gray_w = 5'd0; local_w = 5'd0;
        chk(2, 0, "post_reset", 0, 5'b10100, 1, 0);
        tick(2);

        // Gray count 1..5, one step per cycle; level follows with 2-cycle latency
        for (int k = 0; k < 5; k++) begin
            gray_a = g_tab[k];
            chk(2, 0, "gray_step", k + 1, (k + 1 <= 2) ? 5'b00100 : 5'b00000, 0, 0);
            tick(1);
        end
        chk(1, 0, "gray_final", 5, 5'b00000, 1, 5);
        tick(3);

        // multi-step jumps across the almost_full threshold
        gray_a = 5'b01011;
        chk(2, 0, "jump_13", 13, 5'b00000, 1, 13);
        tick(3);
        gray_a = 5'b01001;
        chk(2, 0, "jump_14", 14, 5'b00010, 1, 14);
        tick(3);

        // wrap: local and remote change together
        local_a = 5'd20; gray_a = 5'b10000;
        chk(2, 0, "wrap_31_20", 11, 5'b00000, 1, 31);
        tick(3);
        gray_a = 5'b00000;
        chk(2, 0, "wrap_0_20", 12, 5'b00000, 1, 0);
        tick(3);

        // exactly full
        local_a = 5'd0; gray_a = 5'b11000;
        chk(2, 0, "full_16", 16, 5'b01010, 1, 16);
        tick(3);

        // over-full pointer distance
        gray_a = 5'b11110;
`ifdef FIFO_GRAY_LEVEL_CHECK_EN
        chk(2, 0, "overflow", 16, 5'b01011, 1, 20);
`else
        chk(2, 0, "overflow", 20, 5'b00010, 1, 20);
`endif
        tick(3);
        gray_a = 5'b00000;
`ifdef FIFO_GRAY_LEVEL_CHECK_EN
        chk(2, 0, "err_sticky", 0, 5'b10101, 1, 0);
        chk(4, 0, "err_sticky_hold", 0, 5'b10101, 1, 0);
`else
        chk(2, 0, "err_sticky", 0, 5'b10100, 1, 0);
        chk(4, 0, "err_sticky_hold", 0, 5'b10100, 1, 0);
`endif
        tick(5);
        areset_a = 1'b1;
        chk(1, 0, "err_reset", 0, 5'b10100, 1, 0);
        tick(1);
        areset_a = 1'b0;
        chk(2, 0, "err_after_reset", 0, 5'b10100, 1, 0);
        tick(3);

        // writer side
        local_w = 5'd3; gray_w = 5'b00001;
        chk(2, 1, "wr_level2", 2, 5'b00100, 1, 1);
        tick(3);
        areset_w = 1'b1;
        chk(1, 1, "wr_mid_reset", 0, 5'b10100, 1, 0);
        tick(1);
        areset_w = 1'b0;
        chk(1, 1, "wr_refill1", 0, 5'b10100, 1, 1);
        chk(2, 1, "wr_refill2", 2, 5'b00100, 1, 1);
        tick(3);
        local_w = 5'd2; gray_w = 5'b10001;
        chk(2, 1, "wr_wrap", 4, 5'b00000, 1, 30);
        tick(3);
        local_w = 5'd19; gray_w = 5'b00010;
        chk(2, 1, "wr_full", 16, 5'b01010, 1, 3);
        tick(3);

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries never checked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
